fp_normalize_round: RTL

//  Back end of the FP adder datapath: consumes the raw mantissa sum produced after alignment and add/sub,

---
 rtl/fp_normalize_round.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: back end of the FP adder. Takes the raw post-add mantissa sum
// with its guard/round/sticky bits, renormalises it (one right shift on carry-out,
// one left shift per cycle on cancellation), rounds to nearest-even and packs an
// IEEE-754 single. Valid/ready on both sides, one operation in flight.
module fp_normalize_round #(
  parameter int EXP_W = 8,
  parameter int MANT_W = 23,
  parameter logic [MANT_W-1:0] QNAN_FRAC = 23'h400000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W+1:0]       in_mant,
  input  logic                    in_guard,
  input  logic                    in_round,
  input  logic                    in_sticky,
  input  logic                    in_is_nan,
  input  logic                    in_is_inf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_result,
  output logic                    out_inexact,
  output logic                    out_overflow
);

  localparam int SUM_W = MANT_W + 2;
  localparam int CNT_W = $clog2(MANT_W + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W:0] EXP_ONES_W = {1'b0, EXP_ONES};
  localparam logic [MANT_W-1:0] FRAC_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MANT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state_reg;

  // Working operand held while normalising and rounding
  logic              sign_reg;
  logic [EXP_W-1:0]  exp_reg;
  logic [SUM_W-1:0]  mant_reg;
  logic              guard_reg;
  logic              round_reg;
  logic              sticky_reg;
  logic [CNT_W-1:0]  shift_cnt_reg;

  // Carry-out right-shift view of the incoming operand
  logic [SUM_W-1:0]  rs_mant;
  logic              rs_guard;
  logic              rs_round;
  logic              rs_sticky;
  logic [EXP_W:0]    rs_exp;
  logic              rs_ovf;
  logic              operand_zero;

  // Normalisation and rounding results for the working operand
  logic              norm_done;
  logic              grs_any;
  logic              round_inc;
  logic [SUM_W-1:0]  rnd_mant;
  logic [EXP_W:0]    rnd_exp;
  logic              rnd_ovf;
  logic [EXP_W+MANT_W:0] pack_result;

  assign in_ready = (state_reg == IDLE) && reset_n;

  // Decode the incoming operand: exact-zero detection and the one-bit right shift on carry-out
  always_comb begin
    rs_mant      = {1'b0, in_mant[SUM_W-1:1]};
    rs_guard     = in_mant[0];
    rs_round     = in_guard;
    rs_sticky    = in_round | in_sticky;
    rs_exp       = {1'b0, in_exp} + (EXP_W+1)'(1);
    rs_ovf       = (rs_exp >= EXP_ONES_W);
    operand_zero = (in_mant == '0) && !in_guard && !in_round && !in_sticky;
  end

  // Normalisation stops on a set hidden bit, a subnormal exponent or the shift limit
  always_comb begin
    norm_done = mant_reg[MANT_W] || (exp_reg == '0) || (exp_reg == EXP_ONE) ||
                (shift_cnt_reg == CNT_MAX);
  end

  // Round to nearest-even, renormalise a rounding carry and pack the result word
  always_comb begin
    grs_any   = guard_reg | round_reg | sticky_reg;
    round_inc = guard_reg & (round_reg | sticky_reg | mant_reg[0]);
    rnd_mant  = mant_reg + SUM_W'(round_inc);
    rnd_exp   = {1'b0, exp_reg};
    // A subnormal that gains its hidden bit is encoded with exponent field 1
    if ((exp_reg == '0) && (rnd_mant[MANT_W] || rnd_mant[SUM_W-1])) begin
      rnd_exp = (EXP_W+1)'(1);
    end
    if (rnd_mant[SUM_W-1]) begin
      rnd_mant = rnd_mant >> 1;
      rnd_exp  = rnd_exp + (EXP_W+1)'(1);
    end
    rnd_ovf     = (rnd_exp >= EXP_ONES_W);
    pack_result = {sign_reg, rnd_exp[EXP_W-1:0], rnd_mant[MANT_W-1:0]};
  end

  // Control FSM with registered result and handshake outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      sign_reg      <= 1'b0;
      exp_reg       <= '0;
      mant_reg      <= '0;
      guard_reg     <= 1'b0;
      round_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
      shift_cnt_reg <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            out_inexact   <= 1'b0;
            out_overflow  <= 1'b0;
            shift_cnt_reg <= '0;
            sign_reg      <= in_sign;
            if (in_is_nan) begin
              out_result <= {1'b0, EXP_ONES, QNAN_FRAC};
              state_reg  <= HOLD;
            end else if (in_is_inf) begin
              out_result <= {in_sign, EXP_ONES, FRAC_ZERO};
              state_reg  <= HOLD;
            end else if (operand_zero) begin
              out_result <= '0;
              state_reg  <= HOLD;
            end else if (in_mant[SUM_W-1]) begin
              if (rs_ovf) begin
                out_result   <= {in_sign, EXP_ONES, FRAC_ZERO};
                out_overflow <= 1'b1;
                out_inexact  <= rs_guard | rs_round | rs_sticky;
                state_reg    <= HOLD;
              end else begin
                mant_reg   <= rs_mant;
                exp_reg    <= rs_exp[EXP_W-1:0];
                guard_reg  <= rs_guard;
                round_reg  <= rs_round;
                sticky_reg <= rs_sticky;
                state_reg  <= NORM;
              end
            end else begin
              mant_reg   <= in_mant;
              exp_reg    <= in_exp;
              guard_reg  <= in_guard;
              round_reg  <= in_round;
              sticky_reg <= in_sticky;
              state_reg  <= NORM;
            end
          end
        end
        NORM: begin
          if (norm_done) begin
            // Unnormalised at the minimum exponent: the result is subnormal
            if (!mant_reg[MANT_W] && (exp_reg == EXP_ONE)) begin
              exp_reg <= '0;
            end
            state_reg <= ROUND;
          end else begin
            mant_reg      <= {mant_reg[SUM_W-2:0], guard_reg};
            guard_reg     <= round_reg;
            round_reg     <= 1'b0;
            exp_reg       <= exp_reg - EXP_ONE;
            shift_cnt_reg <= shift_cnt_reg + CNT_W'(1);
          end
        end
        ROUND: begin
          out_inexact <= grs_any;
          if (rnd_ovf) begin
            out_result   <= {sign_reg, EXP_ONES, FRAC_ZERO};
            out_overflow <= 1'b1;
          end else begin
            out_result <= pack_result;
          end
          out_valid <= 1'b1;
          state_reg <= HOLD;
        end
        HOLD: begin
          // Special results arrive without out_valid; raise it one cycle later
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
